// File: rtl/outlier_collector_if.sv
// Beat-in / outlier-out signal bundle for outlier_collector.
// slave = the collector itself; master = the beat producer and outlier consumer.
interface outlier_collector_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 16,
    parameter int IDX_W = 12
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [LANES-1:0]       in_flags_i;
    logic [LANES*WIDTH-1:0] in_score_i;
    logic [IDX_W-1:0]       in_base_idx_i;
    logic                   in_last_i;
    logic [LANES*CNT_W-1:0] cnt_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [IDX_W-1:0]       out_idx_o;
    logic [WIDTH-1:0]       out_score_o;
    logic [CNT_W-1:0]       outlier_total_o;
    logic                   done_o;

    modport slave (
        input  in_valid_i, in_flags_i, in_score_i, in_base_idx_i, in_last_i, out_ready_i,
        output in_ready_o, cnt_o, out_valid_o, out_idx_o, out_score_o, outlier_total_o, done_o
    );

    modport master (
        output in_valid_i, in_flags_i, in_score_i, in_base_idx_i, in_last_i, out_ready_i,
        input  in_ready_o, cnt_o, out_valid_o, out_idx_o, out_score_o, outlier_total_o, done_o
    );
endinterface

// File: rtl/outlier_collector.sv
// Counts in-interval lanes per row and queues flagged lanes (index, optional score) in a FIFO.
// Latency: accept at t, first push t+1, out_valid_o t+2. Backpressure: SCAN stalls while FIFO full.
// Optional OUTLIER_SCORE_EN: store scores in the FIFO and drive out_score_o (otherwise tied to 0).
module outlier_collector #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 16,
    parameter int IDX_W = 12,
    parameter int DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    outlier_collector_if.slave  bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);
`ifdef OUTLIER_SCORE_EN
    localparam int ENT_W  = IDX_W + WIDTH;
`else
    localparam int ENT_W  = IDX_W;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LANES-1:0]       r_pend;
    logic [IDX_W-1:0]       r_base;
    logic                   r_last;
    logic                   r_row_closed;
    logic [CNT_W-1:0]       r_cnt [LANES];
    logic [CNT_W-1:0]       r_total;
    logic [ENT_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [OCC_W-1:0]       r_occ;

    logic                   w_accept;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_in_ready;
    logic                   w_done;
    logic [LANE_W-1:0]      w_lane;
    logic [LANES-1:0]       w_pend_nxt;
    logic [ENT_W-1:0]       w_entry;
    logic [ENT_W-1:0]       w_head;
    logic [CNT_W-1:0]       w_cnt_base [LANES];
    logic [CNT_W-1:0]       w_cnt_nxt  [LANES];
    logic [CNT_W-1:0]       w_tot_base;
    logic [CNT_W:0]         w_tot_sum;

`ifdef OUTLIER_SCORE_EN
    logic [LANES*WIDTH-1:0] r_score;
`else
    logic                   w_unused_score;
    assign w_unused_score = ^bus.in_score_i;
`endif

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot for a push.
    assign w_full   = (r_occ == OCC_W'(DEPTH));
    assign w_pop    = (r_occ != '0) && bus.out_ready_i;
    assign w_accept = bus.in_valid_i && w_in_ready;

    always_comb begin
        w_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_pend[i]) w_lane = LANE_W'(i);
        end
    end

    assign w_pend_nxt = r_pend & ~(LANES'(1) << w_lane);

`ifdef OUTLIER_SCORE_EN
    assign w_entry = {r_score[w_lane*WIDTH +: WIDTH], r_base + IDX_W'(w_lane)};
`else
    assign w_entry = r_base + IDX_W'(w_lane);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (|bus.in_flags_i)   w_state_nxt = SCAN;
                else if (bus.in_last_i) w_state_nxt = DONE;
            end
            SCAN: if (w_push && (w_pend_nxt == '0)) w_state_nxt = r_last ? DONE : IDLE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            IDLE: w_in_ready = 1'b1;
            SCAN: w_push     = !w_full && (|r_pend);
            DONE: w_done     = 1'b1;
            default: ;
        endcase
    end

    // The first beat after a closed row counts from zero instead of the held totals.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_cnt_base[i] = r_row_closed ? '0 : r_cnt[i];
            w_cnt_nxt[i]  = (!bus.in_flags_i[i] && !(&w_cnt_base[i])) ? w_cnt_base[i] + 1'b1
                                                                     : w_cnt_base[i];
        end
    end

    assign w_tot_base = r_row_closed ? '0 : r_total;
    assign w_tot_sum  = {1'b0, w_tot_base} + (CNT_W+1)'($countones(bus.in_flags_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend       <= '0;
            r_base       <= '0;
            r_last       <= 1'b0;
            r_row_closed <= 1'b0;
            r_total      <= '0;
            for (int i = 0; i < LANES; i++) r_cnt[i] <= '0;
        end else begin
            if (w_accept) begin
                r_pend       <= bus.in_flags_i;
                r_base       <= bus.in_base_idx_i;
                r_last       <= bus.in_last_i;
                r_row_closed <= 1'b0;
                r_total      <= w_tot_sum[CNT_W] ? '1 : w_tot_sum[CNT_W-1:0];
                for (int i = 0; i < LANES; i++) r_cnt[i] <= w_cnt_nxt[i];
            end else if (w_push) begin
                r_pend <= w_pend_nxt;
            end
            if (r_state == DONE) r_row_closed <= 1'b1;
        end
    end

`ifdef OUTLIER_SCORE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)         r_score <= '0;
        else if (w_accept) r_score <= bus.in_score_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.in_ready_o      = w_in_ready && !rst_i;
    assign bus.done_o          = w_done && !rst_i;
    assign bus.out_valid_o     = (r_occ != '0) && !rst_i;
    assign bus.out_idx_o       = rst_i ? '0 : w_head[IDX_W-1:0];
    assign bus.outlier_total_o = rst_i ? '0 : r_total;
`ifdef OUTLIER_SCORE_EN
    assign bus.out_score_o     = rst_i ? '0 : w_head[ENT_W-1:IDX_W];
`else
    assign bus.out_score_o     = '0;
`endif

    always_comb begin
        bus.cnt_o = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.cnt_o[i*CNT_W +: CNT_W] = rst_i ? '0 : r_cnt[i];
        end
    end
endmodule

// File: tb/tb_outlier_collector.sv
// Self-checking bench for outlier_collector: directed corner cases plus randomized traffic
// compared every cycle against a queue/array reference model of the row semantics.
`timescale 1ns/1ps
module tb_outlier_collector;
    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int IDX_W = 12;
    localparam int DEPTH = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    outlier_collector_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    outlier_collector #(
        .WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W), .IDX_W(IDX_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] score;
    } ent_t;

    ent_t             exp_q[$];
    logic [IDX_W-1:0] pop_log[$];
    int unsigned      m_cnt [LANES];
    int unsigned      m_total;
    bit               m_closed;
    bit               m_done_pend;
    int               checks = 0;
    int               errors = 0;
    bit               acc;

    logic                   n_rst, n_vld, n_last, n_rdy;
    logic [LANES-1:0]       n_flags;
    logic [IDX_W-1:0]       n_base;
    logic [LANES*WIDTH-1:0] n_score;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
        m_total     = 0;
        m_closed    = 1'b0;
        m_done_pend = 1'b0;
    endtask

    task automatic model_accept();
        ent_t e;
        int unsigned pc;
        chk_eq("done_before_next_beat", 64'(m_done_pend), 64'd0);
        if (m_closed) begin
            for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
            m_total  = 0;
            m_closed = 1'b0;
        end
        pc = 0;
        for (int i = 0; i < LANES; i++) begin
            if (n_flags[i]) begin
                pc++;
                e.idx = IDX_W'((int'(n_base) + i) % (1 << IDX_W));
`ifdef OUTLIER_SCORE_EN
                e.score = n_score[i*WIDTH +: WIDTH];
`else
                e.score = '0;
`endif
                exp_q.push_back(e);
            end else if (m_cnt[i] < CNT_MAX) begin
                m_cnt[i]++;
            end
        end
        m_total = (m_total + pc > CNT_MAX) ? CNT_MAX : m_total + pc;
        if (n_last) begin
            m_closed    = 1'b1;
            m_done_pend = 1'b1;
        end
    endtask

    task automatic model_pop();
        if (exp_q.size() > 0) begin
            pop_log.push_back(exp_q[0].idx);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_outputs();
        logic [LANES*CNT_W-1:0] want_cnt;
        for (int i = 0; i < LANES; i++) want_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        chk_eq("cnt_o", 64'(bus.cnt_o), 64'(want_cnt));
        chk_eq("outlier_total_o", 64'(bus.outlier_total_o), 64'(m_total));
        if (rst) begin
            chk_eq("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
            chk_eq("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
            chk_eq("rst_done", 64'(bus.done_o), 64'd0);
            chk_eq("rst_out_idx", 64'(bus.out_idx_o), 64'd0);
            chk_eq("rst_out_score", 64'(bus.out_score_o), 64'd0);
        end else begin
            if (bus.out_valid_o) begin
                chk_eq("out_valid_has_entry", 64'(bus.out_valid_o), 64'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    chk_eq("out_idx", 64'(bus.out_idx_o), 64'(exp_q[0].idx));
                    chk_eq("out_score", 64'(bus.out_score_o), 64'(exp_q[0].score));
                end
            end
            if (bus.done_o) begin
                chk_eq("done_expected", 64'(bus.done_o), 64'(m_done_pend));
                m_done_pend = 1'b0;
            end
        end
    endtask

    // One cycle: check at the falling edge, then drive and predict the next rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        rst               = n_rst;
        bus.in_valid_i    = n_vld;
        bus.in_flags_i    = n_flags;
        bus.in_base_idx_i = n_base;
        bus.in_last_i     = n_last;
        bus.in_score_i    = n_score;
        bus.out_ready_i   = n_rdy;
        #1;
        acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.in_valid_i && bus.in_ready_o) begin
                acc = 1'b1;
                model_accept();
            end
            if (bus.out_valid_o && bus.out_ready_i) model_pop();
        end
    endtask

    task automatic send_beat(input logic [LANES-1:0] f, input logic [IDX_W-1:0] b, input bit l);
        n_vld   = 1'b1;
        n_flags = f;
        n_base  = b;
        n_last  = l;
        n_score = {$urandom, $urandom};
        acc     = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) tick();
        chk_eq("beat_accepted", 64'(acc), 64'd1);
        n_vld = 1'b0;
    endtask

    task automatic drain();
        n_vld = 1'b0;
        n_rdy = 1'b1;
        for (int k = 0; k < 300 && (exp_q.size() != 0 || !bus.in_ready_o); k++) tick();
        chk_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        chk_eq("idle_out_valid", 64'(bus.out_valid_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDX_W-1:0] want_wrap [4];
        n_rst = 1'b1; n_vld = 1'b0; n_last = 1'b0; n_rdy = 1'b0;
        n_flags = '0; n_base = '0; n_score = '0;
        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.in_flags_i = '0; bus.in_base_idx_i = '0;
        bus.in_last_i = 1'b0; bus.in_score_i = '0; bus.out_ready_i = 1'b0;
        model_reset();

        repeat (3) tick();
        n_rst = 1'b0;
        tick();
        tick();
        chk_eq("in_ready_after_reset", 64'(bus.in_ready_o), 64'd1);

        // Two outliers, consecutive outputs, latency t+2.
        n_rdy = 1'b1;
        pop_log.delete();
        send_beat(4'b1010, 12'd100, 1'b1);
        tick(); chk_eq("lat_no_valid_t1", 64'(bus.out_valid_o), 64'd0);
        tick(); chk_eq("lat_valid_t2", 64'(bus.out_valid_o), 64'd1);
                chk_eq("first_idx_101", 64'(bus.out_idx_o), 64'd101);
        tick(); chk_eq("second_idx_103", 64'(bus.out_idx_o), 64'd103);
                chk_eq("row_done_pulse", 64'(bus.done_o), 64'd1);
        chk_eq("two_outlier_cnt", 64'(bus.cnt_o), 64'h0000_0001_0000_0001);
        chk_eq("two_outlier_total", 64'(bus.outlier_total_o), 64'd2);

        // No flags, last row: done at t+1, counters restart from zero.
        send_beat(4'b0000, 12'd0, 1'b1);
        tick(); chk_eq("noflag_done_t1", 64'(bus.done_o), 64'd1);
                chk_eq("noflag_cnt", 64'(bus.cnt_o), 64'h0001_0001_0001_0001);
                chk_eq("noflag_total", 64'(bus.outlier_total_o), 64'd0);
                chk_eq("noflag_no_valid", 64'(bus.out_valid_o), 64'd0);
        tick(); chk_eq("done_one_cycle", 64'(bus.done_o), 64'd0);

        // New row after DONE counts from zero.
        send_beat(4'b0001, 12'd0, 1'b0);
        tick(); chk_eq("newrow_cnt", 64'(bus.cnt_o), 64'h0001_0001_0001_0000);
                chk_eq("newrow_total", 64'(bus.outlier_total_o), 64'd1);
        drain();

        // Index wrap-around.
        pop_log.delete();
        want_wrap = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        send_beat(4'b1111, 12'd4094, 1'b0);
        drain();
        chk_eq("wrap_count", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < pop_log.size()) chk_eq("wrap_idx", 64'(pop_log[i]), 64'(want_wrap[i]));

        // FIFO full stall with three beats.
        pop_log.delete();
        n_rdy = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(4'b1111, IDX_W'(200 + 4 * b), 1'b0);
        repeat (6) tick();
        chk_eq("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk_eq("stall_out_valid", 64'(bus.out_valid_o), 64'd1);
        chk_eq("stall_head_idx", 64'(bus.out_idx_o), 64'd200);
        drain();
        chk_eq("stall_count", 64'(pop_log.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            if (i < pop_log.size()) chk_eq("stall_order", 64'(pop_log[i]), 64'(200 + i));

        // Reset in the middle of SCAN.
        n_rdy = 1'b0;
        send_beat(4'b1111, 12'd300, 1'b0);
        tick();
        tick(); chk_eq("mid_scan_valid", 64'(bus.out_valid_o), 64'd1);
        n_rst = 1'b1;
        tick();
        tick(); chk_eq("mid_rst_valid", 64'(bus.out_valid_o), 64'd0);
                chk_eq("mid_rst_cnt", 64'(bus.cnt_o), 64'd0);
        n_rst = 1'b0;
        tick();
        tick(); chk_eq("post_rst_ready", 64'(bus.in_ready_o), 64'd1);
        repeat (4) begin
            tick();
            chk_eq("post_rst_no_push", 64'(bus.out_valid_o), 64'd0);
        end

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            if (!n_vld && ($urandom_range(0, 2) != 0)) begin
                n_vld   = 1'b1;
                n_flags = LANES'($urandom);
                n_base  = IDX_W'($urandom);
                n_last  = ($urandom_range(0, 3) == 0);
                n_score = {$urandom, $urandom};
            end
            n_rdy = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) n_vld = 1'b0;
        end
        drain();
        chk_eq("final_done_pending", 64'(m_done_pend), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/outlier_collector.md
OUTLIER_COLLECTOR -- requirements
Module: outlier_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, fp16 score width.
REQ-002 SHALL have parameter LANES, default 4, lanes per beat.
REQ-003 SHALL have parameter CNT_W, default 16, width of each counter.
REQ-004 SHALL have parameter IDX_W, default 12, element index width for n=4096.
REQ-005 SHALL have parameter DEPTH, default 8, outlier FIFO entries, power of two.
REQ-006 SHALL have clk_i  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have rst_i  in  1  synchronous, active-high reset.
REQ-008 SHALL have in_valid_i  in  1, and in_ready_o  out  1, for the input beat handshake.
REQ-009 SHALL have in_flags_i  in  LANES  per-lane out-of-mode-interval flags.
REQ-010 SHALL have in_score_i  in  LANES*WIDTH  per-lane score s_i.
REQ-011 SHALL have in_base_idx_i  in  IDX_W  element index of lane 0.
REQ-012 SHALL have in_last_i  in  1  marks the last beat of a row.
REQ-013 SHALL have cnt_o  out  LANES*CNT_W  per-lane in-interval counts (interval_cnt).
REQ-014 SHALL have out_valid_o  out  1, and out_ready_i  in  1, for the outlier handshake.
REQ-015 SHALL have out_idx_o  out  IDX_W  outlier element index.
REQ-016 SHALL have out_score_o  out  WIDTH  outlier score.
REQ-017 SHALL have outlier_total_o  out  CNT_W, and done_o  out  1, the row summary.

Function
REQ-018 SHALL implement an FSM with states IDLE, SCAN and DONE; in_ready_o = 1 only in IDLE.
REQ-019 SHALL accept a beat when in_valid_i & in_ready_o; it SHALL latch flags, scores, base index and last.
REQ-020 SHALL, on accept, increment cnt_o[i] by 1 for each lane i whose flag is 0, saturating at 2^CNT_W-1.
REQ-021 SHALL, on accept, add popcount(flags) to outlier_total_o, saturating.
REQ-022 SHALL go from IDLE to SCAN on accept when any flag is set; to DONE if no flag is set and last=1; otherwise stay in IDLE.
REQ-023 SHALL, in SCAN, push the lowest-numbered pending lane each cycle the FIFO is not full, then clear its pending bit.
REQ-024 SHALL form the pushed entry as idx = base_idx + lane (mod 2^IDX_W) and score = in_score_i[lane].
REQ-025 SHALL stall in SCAN without loss while the FIFO is full.
REQ-026 SHALL leave SCAN after the final pending push: to DONE if the latched last=1, else to IDLE.
REQ-027 SHALL make DONE last exactly one cycle with done_o=1, then go to IDLE; cnt_o and outlier_total_o hold their values during DONE.
REQ-028 SHALL clear all counters in the same cycle as the first accept after a DONE; that beat's increments apply from zero.
REQ-029 SHALL drive out_valid_o = FIFO not empty, and pop on out_valid_o & out_ready_i.
REQ-030 SHALL evaluate the full condition on registered occupancy, so a same-cycle pop does not enable a push when full.
REQ-031 SHALL support a simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-032 SHALL have latency: beat accepted at cycle t → first outlier push at t+1 → out_valid_o at t+2.
REQ-033 SHALL present FIFO outputs in push order, with out_idx_o/out_score_o stable while out_valid_o & !out_ready_i.

Reset
REQ-034 SHALL, on rst_i, enter IDLE, empty the FIFO, and clear pending flags and all counters.
REQ-035 SHALL drive outputs during reset: in_ready_o=0, out_valid_o=0, done_o=0, cnt_o=0, outlier_total_o=0, out_idx_o=0, out_score_o=0.
REQ-036 SHALL discard any partially scanned beat on rst_i asserted mid-SCAN, with no further pushes.

Configuration
REQ-037 SHALL, with OUTLIER_SCORE_EN defined, store the score in each FIFO entry and drive it on out_score_o.
REQ-038 SHALL, without OUTLIER_SCORE_EN, store the index only and tie out_score_o to 0; all other behaviour is identical.

Verification
REQ-039 SHALL cover: beat flags=0000, last=1, base=0 → cnt_o={1,1,1,1}, done_o pulses at t+1, no outputs.
REQ-040 SHALL cover: flags=1010, base=100, out_ready_i=1 → out_idx_o 101 then 103 on consecutive cycles, outlier_total_o=2, cnt_o[0]=cnt_o[2]=1.
REQ-041 SHALL cover: out_ready_i=0 with three beats of flags=1111 → FIFO holds 8 entries, SCAN stalls, in_ready_o=0; after out_ready_i=1, all 12 indices emerge in order.
REQ-042 SHALL cover: base=4094, flags=1111 → indices 4094, 4095, 0, 1.
REQ-043 SHALL cover: rst_i asserted in SCAN after one push → out_valid_o=0 next cycle, counters 0, in_ready_o=1 after release.
REQ-044 SHALL cover: a row closing with done_o, then a new beat with flags=0001 → cnt_o={1,1,1,0} from zero, outlier_total_o=1.
